sram_arbiter: RTL and testbench

Shares the single off-chip SRAM between the CPU memory port (driven by the control unit's read/write strobes and MAR/MDR) and a debug/loader port used to preload or inspect program memory. It grants one requester at a time, drives the SRAM control strobes for a fixed number of wait-state cycles, and returns read data with a one-cycle acknowledge pulse. It sits between the CPU datapath's memory interface and the SRAM pins.

---
 rtl/sram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the CPU memory port and a debug/loader port.
// Latency: ack WAIT_CYCLES+1 cycles after a request is sampled in IDLE; one access per WAIT_CYCLES+2 cycles.
// Backpressure: requests are level-held until ack; a losing or late request simply waits in IDLE.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests
// (default build uses fixed priority, debug port over CPU port).
module sram_arbiter #(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    // CPU port (MAR/MDR side)
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    // debug / loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    // Counter only needs to hold WAIT_CYCLES-1; keep at least one bit for WAIT_CYCLES=1.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              op_we, op_we_nxt;
    logic              grant_dbg, grant_dbg_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt;
    logic              cpu_ack_nxt, dbg_ack_nxt;
    logic              cap_cpu, cap_dbg;
    logic              pick_dbg;
    logic              sel_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_dbg;

    // Winner selection: on a tie the port that did not win last time goes first.
    always_comb begin
        pick_dbg = dbg_req;
        if (dbg_req && cpu_req) begin
            pick_dbg = !last_dbg;
        end
    end

    // Last-grant tracking, updated on every grant taken in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dbg <= 1'b0;
        end else if (state == IDLE && (cpu_req || dbg_req)) begin
            last_dbg <= pick_dbg;
        end
    end
`else
    // Fixed priority: the debug port always wins a tie.
    assign pick_dbg = dbg_req;
`endif

    assign sel_we = pick_dbg ? dbg_we : cpu_we;

    // FSM state and access counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and next-output decode; strobes are computed one cycle early so the pins come straight from flops.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_we_nxt     = op_we;
        grant_dbg_nxt = grant_dbg;
        addr_nxt      = sram_addr;
        wdata_nxt     = sram_dq_o;
        ce_n_nxt      = 1'b1;
        oe_n_nxt      = 1'b1;
        we_n_nxt      = 1'b1;
        dq_oe_nxt     = 1'b0;
        cpu_ack_nxt   = 1'b0;
        dbg_ack_nxt   = 1'b0;
        cap_cpu       = 1'b0;
        cap_dbg       = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_nxt     = ACCESS;
                    cnt_nxt       = CNT_LOAD;
                    grant_dbg_nxt = pick_dbg;
                    op_we_nxt     = sel_we;
                    addr_nxt      = pick_dbg ? dbg_addr  : cpu_addr;
                    wdata_nxt     = pick_dbg ? dbg_wdata : cpu_wdata;
                    ce_n_nxt      = 1'b0;
                    oe_n_nxt      = sel_we;
                    we_n_nxt      = !sel_we;
                    dq_oe_nxt     = sel_we;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // Last strobe cycle: read data is sampled here, strobes drop for the hold cycle.
                    state_nxt   = DONE;
                    cap_cpu     = !op_we && !grant_dbg;
                    cap_dbg     = !op_we &&  grant_dbg;
                    cpu_ack_nxt = !grant_dbg;
                    dbg_ack_nxt =  grant_dbg;
                end else begin
                    cnt_nxt   = cnt - 1'b1;
                    ce_n_nxt  = 1'b0;
                    oe_n_nxt  = op_we;
                    we_n_nxt  = !op_we;
                    dq_oe_nxt = op_we;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Access context, SRAM pin registers and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we      <= 1'b0;
            grant_dbg  <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
        end else begin
            op_we      <= op_we_nxt;
            grant_dbg  <= grant_dbg_nxt;
            sram_addr  <= addr_nxt;
            sram_dq_o  <= wdata_nxt;
            sram_ce_n  <= ce_n_nxt;
            sram_oe_n  <= oe_n_nxt;
            sram_we_n  <= we_n_nxt;
            sram_dq_oe <= dq_oe_nxt;
            cpu_ack    <= cpu_ack_nxt;
            dbg_ack    <= dbg_ack_nxt;
        end
    end

    // Per-port read result registers; only a completed read on that port changes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            if (cap_cpu) begin
                cpu_rdata <= sram_dq_i;
            end
            if (cap_dbg) begin
                dbg_rdata <= sram_dq_i;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: main instance with WAIT_CYCLES=3, second instance with WAIT_CYCLES=1.
// Each instance talks to a small behavioural SRAM indexed by the low address byte.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // main instance (WAIT_CYCLES = 3)
    logic          cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] cpu_addr, dbg_addr, sram_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata, sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;

    // second instance (WAIT_CYCLES = 1)
    logic          w1_cpu_req, w1_cpu_we, w1_cpu_ack, w1_dbg_req, w1_dbg_we, w1_dbg_ack;
    logic [AW-1:0] w1_cpu_addr, w1_dbg_addr, w1_sram_addr;
    logic [DW-1:0] w1_cpu_wdata, w1_cpu_rdata, w1_dbg_wdata, w1_dbg_rdata, w1_sram_dq_o, w1_sram_dq_i;
    logic          w1_sram_dq_oe, w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n, w1_busy;

    int vectors = 0;
    int miscompares = 0;

    sram_arbiter #(.WAIT_CYCLES(3), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .busy(busy)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .cpu_req(w1_cpu_req), .cpu_we(w1_cpu_we), .cpu_addr(w1_cpu_addr), .cpu_wdata(w1_cpu_wdata),
        .cpu_ack(w1_cpu_ack), .cpu_rdata(w1_cpu_rdata),
        .dbg_req(w1_dbg_req), .dbg_we(w1_dbg_we), .dbg_addr(w1_dbg_addr), .dbg_wdata(w1_dbg_wdata),
        .dbg_ack(w1_dbg_ack), .dbg_rdata(w1_dbg_rdata),
        .sram_addr(w1_sram_addr), .sram_dq_o(w1_sram_dq_o), .sram_dq_oe(w1_sram_dq_oe),
        .sram_dq_i(w1_sram_dq_i), .sram_ce_n(w1_sram_ce_n), .sram_oe_n(w1_sram_oe_n),
        .sram_we_n(w1_sram_we_n), .busy(w1_busy)
    );

    // Behavioural SRAMs with a bench-side preload port.
    logic          pl_we;
    logic [7:0]    pl_addr;
    logic [DW-1:0] pl_dat;
    logic [DW-1:0] mem  [0:255];
    logic [DW-1:0] mem1 [0:255];

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_dat;
        else if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;
    end
    always @(posedge clk) begin
        if (pl_we) mem1[pl_addr] <= pl_dat;
        else if (!w1_sram_ce_n && !w1_sram_we_n) mem1[w1_sram_addr[7:0]] <= w1_sram_dq_o;
    end
    assign sram_dq_i    = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : '0;
    assign w1_sram_dq_i = (!w1_sram_ce_n && !w1_sram_oe_n) ? mem1[w1_sram_addr[7:0]] : '0;

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_dat = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Reset values on both instances.
    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        w1_cpu_req = 0; w1_cpu_we = 0; w1_cpu_addr = '0; w1_cpu_wdata = '0;
        w1_dbg_req = 0; w1_dbg_we = 0; w1_dbg_addr = '0; w1_dbg_wdata = '0;
        pl_we = 0; pl_addr = '0; pl_dat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy} !== 7'b1110000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 1110000",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy});
        end
        vectors++;
        if ({sram_addr, sram_dq_o, cpu_rdata, dbg_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h dq_o %h cpu_rdata %h dbg_rdata %h expected all zero",
                     sram_addr, sram_dq_o, cpu_rdata, dbg_rdata);
        end
        vectors++;
        if ({w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n, w1_sram_dq_oe, w1_cpu_ack, w1_dbg_ack, w1_busy} !== 7'b1110000) begin
            miscompares++;
            $display("FAIL reset_w1_ctrl: got %b expected 1110000",
                     {w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n, w1_sram_dq_oe, w1_cpu_ack, w1_dbg_ack, w1_busy});
        end
    endtask

    // CPU read of 0x00010 holding 0x1234: three read-strobe cycles then ack.
    task automatic test_cpu_read();
        logic [6:0] exp;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp = (i <= 3) ? 7'b0010001 : (i == 4) ? 7'b1110101 : 7'b1110000;
            vectors++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy} !== exp) begin
                miscompares++;
                $display("FAIL cpu_read_ctrl cyc%0d: got %b expected %b", i,
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy}, exp);
            end
            if (i <= 4) begin
                vectors++;
                if (sram_addr !== 20'h00010) begin
                    miscompares++;
                    $display("FAIL cpu_read_addr cyc%0d: got %h expected 00010", i, sram_addr);
                end
            end
            if (i == 4) begin
                vectors++;
                if (cpu_rdata !== 16'h1234) begin
                    miscompares++;
                    $display("FAIL cpu_read_data: got %h expected 1234", cpu_rdata);
                end
                cpu_req = 0;
            end
        end
    endtask

    // Debug write of 0xBEEF to 0x00020; address and data held through the DONE cycle.
    task automatic test_dbg_write();
        logic [6:0] exp;
        @(negedge clk);
        dbg_req = 1; dbg_we = 1; dbg_addr = 20'h00020; dbg_wdata = 16'hBEEF;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exp = (i <= 3) ? 7'b0101001 : (i == 4) ? 7'b1110011 : 7'b1110000;
            vectors++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy} !== exp) begin
                miscompares++;
                $display("FAIL dbg_write_ctrl cyc%0d: got %b expected %b", i,
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy}, exp);
            end
            if (i <= 4) begin
                vectors++;
                if ({sram_addr, sram_dq_o} !== {20'h00020, 16'hBEEF}) begin
                    miscompares++;
                    $display("FAIL dbg_write_hold cyc%0d: addr %h data %h expected 00020 beef", i, sram_addr, sram_dq_o);
                end
            end
            if (i == 4) begin
                vectors++;
                if ({cpu_rdata, dbg_rdata} !== {16'h1234, 16'h0000}) begin
                    miscompares++;
                    $display("FAIL dbg_write_rdata: cpu %h dbg %h expected 1234 0000", cpu_rdata, dbg_rdata);
                end
                dbg_req = 0; dbg_we = 0;
            end
        end
        vectors++;
        if (mem[8'h20] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL dbg_write_mem: got %h expected beef", mem[8'h20]);
        end
    endtask

    // Both ports request on the same edge: winner acks after 4 cycles, loser 5 cycles later.
    task automatic test_simultaneous();
        int cpu_t = -1;
        int dbg_t = -1;
        int exp_cpu_t, exp_dbg_t;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_cpu_t = 4; exp_dbg_t = 9;   // last grant went to dbg, so cpu wins
`else
        exp_cpu_t = 9; exp_dbg_t = 4;   // dbg always wins
`endif
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00020;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (cpu_t < 0) cpu_t = i;
                cpu_req = 0;
            end
            if (dbg_ack) begin
                if (dbg_t < 0) dbg_t = i;
                dbg_req = 0;
            end
        end
        cpu_req = 0; dbg_req = 0;
        vectors++;
        if (dbg_t != exp_dbg_t) begin
            miscompares++;
            $display("FAIL simul_dbg_ack_cycle: got %0d expected %0d", dbg_t, exp_dbg_t);
        end
        vectors++;
        if (cpu_t != exp_cpu_t) begin
            miscompares++;
            $display("FAIL simul_cpu_ack_cycle: got %0d expected %0d", cpu_t, exp_cpu_t);
        end
        vectors++;
        if ({cpu_rdata, dbg_rdata} !== {16'h1234, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL simul_rdata: cpu %h dbg %h expected 1234 beef", cpu_rdata, dbg_rdata);
        end
    endtask

    // CPU reads back the debug-written word.
    task automatic test_readback();
        int t = -1;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00020;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cpu_ack && t < 0) begin
                t = i;
                cpu_req = 0;
                vectors++;
                if (cpu_rdata !== 16'hBEEF) begin
                    miscompares++;
                    $display("FAIL readback_data: got %h expected beef", cpu_rdata);
                end
            end
        end
        cpu_req = 0;
        vectors++;
        if (t != 4) begin
            miscompares++;
            $display("FAIL readback_ack_cycle: got %0d expected 4", t);
        end
    endtask

    // Request held high: an access every 5 cycles, busy low for one cycle in between.
    task automatic test_back_to_back();
        int acks = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            vectors++;
            if ({cpu_ack, dbg_ack, busy} !== {(i % 5 == 4), 1'b0, (i % 5 != 0)}) begin
                miscompares++;
                $display("FAIL b2b_ack_busy cyc%0d: got %b expected %b", i, {cpu_ack, dbg_ack, busy},
                         {(i % 5 == 4), 1'b0, (i % 5 != 0)});
            end
            if (i == 4) begin
                vectors++;
                if (cpu_rdata !== 16'h1234) begin
                    miscompares++;
                    $display("FAIL b2b_data: got %h expected 1234", cpu_rdata);
                end
            end
            if (i == 14) cpu_req = 0;
        end
        vectors++;
        if (acks != 3) begin
            miscompares++;
            $display("FAIL b2b_ack_count: got %0d expected 3", acks);
        end
    endtask

    // Asynchronous reset in the second write-strobe cycle aborts the access without an ack.
    task automatic test_reset_mid_write();
        int acks = 0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00030; cpu_wdata = 16'h5555;
        @(negedge clk);
        vectors++;
        if ({sram_ce_n, sram_we_n, sram_dq_oe} !== 3'b001) begin
            miscompares++;
            $display("FAIL rstmid_first_cycle: got %b expected 001", {sram_ce_n, sram_we_n, sram_dq_oe});
        end
        @(posedge clk);
        #2;
        vectors++;
        if ({sram_ce_n, sram_we_n, sram_dq_oe} !== 3'b001) begin
            miscompares++;
            $display("FAIL rstmid_second_cycle: got %b expected 001", {sram_ce_n, sram_we_n, sram_dq_oe});
        end
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0;
        #1;
        vectors++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy} !== 7'b1110000) begin
            miscompares++;
            $display("FAIL rstmid_ctrl: got %b expected 1110000",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, cpu_ack, dbg_ack, busy});
        end
        vectors++;
        if ({sram_addr, sram_dq_o, cpu_rdata, dbg_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_data: addr %h dq_o %h cpu %h dbg %h expected all zero",
                     sram_addr, sram_dq_o, cpu_rdata, dbg_rdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack || busy) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_ack: got %0d ack/busy cycles expected 0", acks);
        end
    endtask

    // WAIT_CYCLES=1 instance: one strobe cycle, ack two cycles after the request.
    task automatic test_wait1();
        logic [6:0] exp;
        @(negedge clk);
        w1_cpu_req = 1; w1_cpu_we = 0; w1_cpu_addr = 20'h00044;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            exp = (i == 1) ? 7'b0010001 : (i == 2) ? 7'b1110101 : 7'b1110000;
            vectors++;
            if ({w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n, w1_sram_dq_oe, w1_cpu_ack, w1_dbg_ack, w1_busy} !== exp) begin
                miscompares++;
                $display("FAIL wait1_ctrl cyc%0d: got %b expected %b", i,
                         {w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n, w1_sram_dq_oe, w1_cpu_ack, w1_dbg_ack, w1_busy}, exp);
            end
            if (i == 2) begin
                vectors++;
                if (w1_cpu_rdata !== 16'hA5A5) begin
                    miscompares++;
                    $display("FAIL wait1_data: got %h expected a5a5", w1_cpu_rdata);
                end
                w1_cpu_req = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        preload(8'h10, 16'h1234);
        preload(8'h44, 16'hA5A5);
        test_cpu_read();
        test_dbg_write();
        test_simultaneous();
        test_readback();
        test_back_to_back();
        test_reset_mid_write();
        test_wait1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
